// File: rtl/serial_sub_ctrl_pkg.sv
// rtl/serial_sub_ctrl_pkg.sv - shared state encodings and default width for serial_sub_ctrl
//
// Purpose: single home for the FSM encodings and the default operand width so
// the controller and anything that decodes its state agree on the values.
// Ports: none (package).
package serial_sub_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2'b11 is deliberately unused; the controller steers it back to idle.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/fs_cell.sv
// rtl/fs_cell.sv - 1-bit full subtractor built from two half subtractors
//
// Purpose: combinational x - y - bin for one bit position.
// hs ports:      x, y (in)        -> d (difference), bo (borrow out)
// fs_cell ports: a, b, bin (in)   -> d (difference), bo (borrow out)
module hs (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);
  logic d1;
  logic bo1;
  logic bo2;

  hs u_hs0 (.x(a),  .y(b),   .d(d1), .bo(bo1));
  hs u_hs1 (.x(d1), .y(bin), .d(d),  .bo(bo2));

  // Second stage only borrows when a==b and a borrow is coming in.
  assign bo = bo1 | bo2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial WIDTH-bit subtractor with start/done handshake
//
// Purpose: accepts a and b when ready, runs one full-subtractor cell LSB-first
// for WIDTH clocks, then presents diff = (a-b) mod 2^WIDTH and borrow_out = (a<b)
// with a one-cycle done pulse.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, a, b       request and operands, sampled only on the accepting edge
//   ready, busy, done state decodes (idle / running / result-valid pulse)
//   diff, borrow_out  registered result, held until the next run completes
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH:0]   r_ext;
  logic [WIDTH-1:0] r_next;

  fs_cell u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (brw),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // New bit enters at the MSB; after WIDTH shifts the first bit sits at the LSB.
  // Going through a WIDTH+1 vector keeps the slice legal when WIDTH is 1.
  assign r_ext  = {cell_d, r_sh};
  assign r_next = r_ext[WIDTH:1];

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          brw  <= cell_bo;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff       <= r_next;
            borrow_out <= cell_bo;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard bench for serial_sub_ctrl at WIDTH 8, 1 and 32
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, bo8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ready1, busy1, done1, bo1;
  logic [0:0] diff1;

  logic        start32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ready32, busy32, done32, bo32;
  logic [31:0] diff32;

  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );
  serial_sub_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );
  serial_sub_ctrl #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
    .ready(ready32), .busy(busy32), .done(done32), .diff(diff32), .borrow_out(bo32)
  );

  int checks = 0;
  int failures = 0;
  logic [8:0] sbq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse on the 8-bit instance consumes one expectation.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && done8) begin
      check("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("diff8", diff8, e[7:0]);
        check("borrow8", bo8, e[8]);
      end
    end
  end

  function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a - b;
    return {a < b, d};
  endfunction

  task automatic wait_ready8();
    int k = 0;
    @(negedge clk);
    while (!ready8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ready8) check("ready_timeout", ready8, 1);
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done8 && n < 100);
    check("done8_seen", done8, 1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    int n;
    wait_ready8();
    a8 = a; b8 = b; start8 = 1'b1;
    sbq.push_back(ref_sub(a, b));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    wait_done8(n);
    check("latency8", n, 8);
    @(negedge clk);
    check("done_one_cycle", done8, 0);
    check("ready_after_done", ready8, 1);
  endtask

  task automatic op1(input logic a, input logic b, input logic ed, input logic eb);
    int n = 0;
    @(negedge clk);
    a1 = a; b1 = b; start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done1 && n < 100);
    check("w1_done", done1, 1);
    check("w1_latency", n + 1, 2);
    check("w1_diff", diff1, ed);
    check("w1_borrow", bo1, eb);
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ed, input logic eb);
    int n = 0;
    @(negedge clk);
    a32 = a; b32 = b; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done32 && n < 100);
    check("w32_done", done32, 1);
    check("w32_latency", n + 1, 33);
    check("w32_diff", diff32, ed);
    check("w32_borrow", bo32, eb);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int k;
    int n;
    int seen;
    logic [7:0] ca[6];
    logic [7:0] cb[6];
    ca = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h80, 8'h7F};
    cb = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h80};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", ready8, 1);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_borrow", bo8, 0);
    rst_n = 1'b1;

    // Directed basics
    run_op(8'h5A, 8'h3C);
    run_op(8'h00, 8'h01);
    run_op(8'hA5, 8'hA5);

    // Start held high: operand changes during RUN/DONE must not matter
    wait_ready8();
    a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
    sbq.push_back(ref_sub(8'h33, 8'h44));
    @(posedge clk);
    #1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!done8) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
    end while (!done8 && k < 50);
    check("held_done1", done8, 1);
    a8 = 8'h10; b8 = 8'h20;
    sbq.push_back(ref_sub(8'h10, 8'h20));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("held_idle_ready", ready8, 1);
      if (n == 2) begin
        check("held_accepted", busy8, 1);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
    end while (!done8 && n < 50);
    check("held_interval", n, 10);
    @(negedge clk);
    check("held_ready_after", ready8, 1);

    // Reset mid-run after four bits
    a8 = 8'hC3; b8 = 8'h12; start8 = 1'b1;
    sbq.push_back(ref_sub(8'hC3, 8'h12));
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    check("midrst_diff", diff8, 0);
    check("midrst_borrow", bo8, 0);
    check("midrst_ready", ready8, 1);
    check("midrst_busy", busy8, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("midrst_no_done", seen, 0);
    run_op(8'hC3, 8'h12);

    // Corners and random pairs
    for (int i = 0; i < 6; i++) run_op(ca[i], cb[i]);
    repeat (1500) run_op(8'($urandom), 8'($urandom));

    // Other widths
    op1(1'b0, 1'b1, 1'b1, 1'b1);
    op1(1'b1, 1'b1, 1'b0, 1'b0);
    op32(32'h0, 32'hFFFF_FFFF, 32'h1, 1'b1);
    op32(32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
